// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_INSTR_W  = 16;
    localparam int unsigned DEF_MAX_WAIT = 15;

    // Opcode field position within an instruction word
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_JMP = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        ADV   = 3'd3,
        FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory read port plus downstream instruction handshake of the fetch sequencer.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
);

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_data;

    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;

    // Fetch sequencer side
    modport master (
        output mem_req, mem_addr, instr_out, instr_valid,
        input  mem_ack, mem_data, instr_ready
    );

    // Memory / downstream side
    modport slave (
        input  mem_req, mem_addr, instr_out, instr_valid,
        output mem_ack, mem_data, instr_ready
    );

endinterface

// File: rtl/fetch_jump_dec.sv
// Jump decode: JMP opcode detect and page-relative target build.
module fetch_jump_dec
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [OPC_W-1:0]   pc_page,
    output logic               is_jump,
    output logic [ADDR_W-1:0]  target
);

    // Target keeps the current PC page and takes the offset from the instruction
    always_comb begin
        is_jump = (instr[OPC_MSB:OPC_LSB] == OPC_JMP);
        target  = {pc_page, instr[ADDR_W-OPC_W-1:0]};
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC -> memory read -> downstream handshake -> PC advance/jump.
// Optional build macro FETCH_CTRL_TIMEOUT_EN adds the memory wait counter and sticky fault.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INSTR_W  = DEF_INSTR_W
`ifdef FETCH_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              halt,
    fetch_ctrl_if.master      bus,
    output logic              controle,
    output logic              hab_jump,
    output logic [ADDR_W-1:0] jump_pc,
    output logic              fault
);

    state_t state;
    state_t state_nxt;

    logic              is_jump;
    logic [ADDR_W-1:0] jump_tgt;
    logic              timeout_c;

    fetch_jump_dec #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_jump_dec (
        .instr   (bus.instr_out),
        .pc_page (pc_in[ADDR_W-1 -: OPC_W]),
        .is_jump (is_jump),
        .target  (jump_tgt)
    );

`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count unacknowledged request cycles of the current fetch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == REQ && !bus.mem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Timeout fires on the edge where the count would reach the limit
    always_comb begin
        timeout_c = ((wait_cnt + CNT_W'(1)) == CNT_W'(MAX_WAIT));
    end

    // Sticky fault, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_nxt == FAULT);
        end
    end
`else
    assign timeout_c = 1'b0;
    assign fault     = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; an ack on the timeout edge takes priority
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!halt) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_nxt = HOLD;
                end else if (timeout_c) begin
                    state_nxt = FAULT;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    state_nxt = ADV;
                end
            end
            ADV: begin
                state_nxt = IDLE;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs derived from the next state and the datapath captures
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.instr_out   <= '0;
            bus.instr_valid <= 1'b0;
            controle        <= 1'b0;
            hab_jump        <= 1'b0;
            jump_pc         <= '0;
        end else begin
            bus.mem_req     <= (state_nxt == REQ);
            bus.instr_valid <= (state_nxt == HOLD);
            controle        <= (state_nxt == ADV) && !is_jump;
            hab_jump        <= (state_nxt == ADV) && is_jump;
            if (state == IDLE && !halt) begin
                bus.mem_addr <= pc_in;
            end
            if (state == REQ && bus.mem_ack) begin
                bus.instr_out <= bus.mem_data;
            end
            if (state == HOLD && bus.instr_ready) begin
                jump_pc <= jump_tgt;
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that sits on the consumer side of the program counter. It reads the current PC value, issues a word read to instruction memory and waits for acknowledgement. It then hands the instruction downstream with a valid/ready handshake, and closes the loop by driving the PC's advance (`controle`) or jump (`hab_jump`/`jump_pc`) inputs.

## Interface
- `ADDR_W`, 16: PC / memory address width.
- `INSTR_W`, 16: instruction word width.
- `MAX_WAIT`, 15: memory wait cycles tolerated before fault.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `pc_in`  in  ADDR_W  current PC value (the PC's `pc_out`).
- `halt`  in  1  when high, no new fetch is started.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  ADDR_W  read address.
- `mem_ack`  in  1  memory has data; may be high in the first `mem_req` cycle.
- `mem_data`  in  INSTR_W  read data, valid when `mem_ack` is high.
- `instr_out`  out  INSTR_W  fetched instruction.
- `instr_valid`  out  1  `instr_out` is valid.
- `instr_ready`  in  1  downstream accepts `instr_out`.
- `controle`  out  1  one-cycle pulse: PC += 1.
- `hab_jump`  out  1  one-cycle pulse: PC loads `jump_pc`.
- `jump_pc`  out  ADDR_W  jump target, valid while `hab_jump` is high.
- `fault`  out  1  sticky memory-timeout flag.

## Operation
- States:
  - IDLE: if `!halt`, latch `mem_addr <= pc_in`, clear the wait counter, go to REQ. Otherwise stay in IDLE.
  - REQ: `mem_req` = 1.
    - If `mem_ack` is high: `instr_out <= mem_data`, go to HOLD.
    - Otherwise increment the wait counter. When the counter reaches `MAX_WAIT` with no ack, go to FAULT.
  - HOLD: `instr_valid` = 1. When `instr_valid && instr_ready` at an edge, go to ADV.
  - ADV: exactly one of `controle` or `hab_jump` is high for this single cycle, then go to IDLE.
  - FAULT: `mem_req` = 0, `fault` = 1. Exit only by reset.
- Jump decode: opcode `instr_out[15:12] == 4'hF` is a JMP.
  - Target = `{pc_in[15:12], instr_out[11:0]}`.
  - In ADV, JMP drives `hab_jump` = 1 and `controle` = 0. All other opcodes drive `controle` = 1 and `hab_jump` = 0.
  - `controle` and `hab_jump` are never high together.
- Halt:
  - `halt` is sampled only in IDLE.
  - Asserting it mid-fetch does not abort the fetch. The current instruction completes through ADV, then the block parks in IDLE.
- `mem_addr` holds stable from REQ entry until the next IDLE→REQ transition.
- Address wrap: `pc_in = 16'hFFFF` is fetched normally. Wrap-around is owned by the PC.
- Reset values: state IDLE, wait counter 0; `mem_req`, `mem_addr`, `instr_out`, `instr_valid`, `controle`, `hab_jump`, `jump_pc`, `fault` all 0.
- Reset during REQ or HOLD drops `mem_req` and `instr_valid` immediately (asynchronous).

## Timing
- All outputs are registered or decoded from the registered state only. There is no combinational path from `mem_ack` or `instr_ready` to any output.
- Best case, with `mem_ack` in the first REQ cycle and `instr_ready` tied high: IDLE→REQ→HOLD→ADV→IDLE, i.e. 4 cycles per instruction.
- Each memory wait cycle adds 1 cycle. Each cycle `instr_ready` is low in HOLD adds 1 cycle.
- The PC updates on the edge that ends ADV. The following IDLE cycle therefore sees the new `pc_in`, and no extra bubble is needed.
- FAULT is entered on the edge where the counter reaches `MAX_WAIT` without ack. An ack on that same edge wins: the block captures the data and goes to HOLD, not FAULT.

## Configuration
- `FETCH_CTRL_TIMEOUT_EN` defined: wait counter, FAULT state and the `fault` output behave as above.
- Not defined:
  - No wait counter is built and the FAULT state is unreachable.
  - REQ waits indefinitely for `mem_ack`.
  - `fault` is tied to 0.

## Structure
- `fetch_ctrl_pkg`:
  - state enum (IDLE, REQ, HOLD, ADV, FAULT)
  - `OPC_JMP = 4'hF`
  - opcode field position constants
- Sub-module `fetch_jump_dec`: combinational; takes `instr_out` and `pc_in`, produces `is_jump` and the target.

## Test plan
- Reset, `halt` = 0, `pc_in` = 0x0010, memory acks with 0x1234 in the first cycle, `instr_ready` = 1 → `mem_addr` = 0x0010, `instr_out` = 0x1234, `controle` pulses 1 cycle, 4-cycle period.
- `mem_data` = 0xF0AB, `pc_in` = 0x3005 → `hab_jump` pulses, `jump_pc` = 0x30AB, `controle` stays 0.
- Memory acks after 3 wait cycles and `instr_ready` is low 2 cycles in HOLD → `instr_valid` held 3 cycles, `instr_out` stable, single `controle` pulse.
- `halt` raised in REQ → current fetch completes with one `controle` pulse, then the block stays in IDLE with `mem_req` = 0 until `halt` drops.
- With `FETCH_CTRL_TIMEOUT_EN`, no ack for 15 cycles → `fault` = 1, `mem_req` = 0, ack afterwards ignored. Without the macro, the same stimulus → `mem_req` held high and `fault` = 0.
- `reset_n` asserted in HOLD → `instr_valid`, `instr_out` and `mem_addr` reach 0 before the next edge. After release, the block fetches from the current `pc_in`.
